// File: rtl/ext_sram_target_if.sv
// Byte-wide host bus of the external SRAM target: one-cycle read/write strobes
// qualified by a byte address, and the registered read byte returned by the target.
interface ext_sram_target_if;
  logic [31:0] ext_sram_addr_i;
  logic        ext_sram_read_i;
  logic        ext_sram_write_i;
  logic [7:0]  ext_sram_wdata_i;
  logic [7:0]  ext_sram_rdata_o;

  modport master (
    output ext_sram_addr_i, ext_sram_read_i, ext_sram_write_i, ext_sram_wdata_i,
    input  ext_sram_rdata_o
  );

  modport slave (
    input  ext_sram_addr_i, ext_sram_read_i, ext_sram_write_i, ext_sram_wdata_i,
    output ext_sram_rdata_o
  );
endinterface

// File: rtl/ext_sram_target.sv
// Byte-bus to 32-bit SRAM macro bridge with a one-word write-combining buffer,
// idle/forced write-back and a two-cycle read pipeline that bypasses buffered bytes.
module ext_sram_target #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORDS_LOG2 = 10,
  parameter int          IDLE_FLUSH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ext_sram_target_if.slave      bus,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [WORDS_LOG2-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  flush_req_i,
  output logic                  flush_done_o,
  output logic                  dirty_o,
  output logic                  err_o
);

  localparam int                CNT_W     = $clog2(IDLE_FLUSH + 1) + 1;
  localparam logic [CNT_W-1:0]  IDLE_LAST = (IDLE_FLUSH > 0) ? CNT_W'(IDLE_FLUSH - 1) : '0;
  localparam logic [32:0]       WIN_BYTES = 33'd4 << WORDS_LOG2;

  typedef enum logic [1:0] {CLEAN, DIRTY, FLUSH_PEND} state_t;

  state_t                state;
  logic [31:0]           buf_data;
  logic [WORDS_LOG2-1:0] buf_tag;
  logic [3:0]            buf_mask;
  logic [CNT_W-1:0]      idle_cnt;

  logic                  rd_pend;
  logic                  rd_oob;
  logic                  rd_hit;
  logic [1:0]            rd_lane;
  logic [7:0]            rd_byte;
  logic [7:0]            rdata_q;
  logic                  flush_done_q;
  logic                  err_q;

  logic [31:0]           offset;
  logic                  in_win;
  logic [WORDS_LOG2-1:0] word;
  logic [1:0]            lane;
  logic [3:0]            lane_bit;
  logic                  rd;
  logic                  wr;
  logic                  wr_ok;
  logic                  dirty;
  logic                  timeout;
  logic                  wb;
  logic [31:0]           mask_bits;

  assign offset    = bus.ext_sram_addr_i - BASE_ADDR;
  assign in_win    = {1'b0, offset} < WIN_BYTES;
  assign word      = offset[WORDS_LOG2+1:2];
  assign lane      = offset[1:0];
  assign lane_bit  = 4'b0001 << lane;
  assign rd        = rst_ni & bus.ext_sram_read_i;
  assign wr        = rst_ni & bus.ext_sram_write_i;
  assign wr_ok     = wr & ~rd & in_win;
  assign dirty     = |buf_mask;
  assign timeout   = dirty & ~rd & ~wr & (idle_cnt >= IDLE_LAST);
  // Any write-back trigger is honoured only in a cycle without a read strobe.
  assign wb        = dirty & ~rd &
                     (flush_req_i | (state == FLUSH_PEND) | timeout | (wr_ok & (word != buf_tag)));
  assign mask_bits = {{8{buf_mask[3]}}, {8{buf_mask[2]}}, {8{buf_mask[1]}}, {8{buf_mask[0]}}};

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (rd && in_win) begin
      mem_req_o  = 1'b1;
      mem_be_o   = 4'hF;
      mem_addr_o = word;
    end else if (wb) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_be_o    = buf_mask;
      mem_addr_o  = buf_tag;
      mem_wdata_o = buf_data & mask_bits;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= CLEAN;
      buf_data <= 32'h0;
      buf_tag  <= '0;
      buf_mask <= 4'b0000;
      idle_cnt <= '0;
    end else begin
      if (wb) begin
        // A write that triggered the write-back restarts the buffer with only its byte.
        buf_mask <= wr_ok ? lane_bit : 4'b0000;
        buf_data <= wr_ok ? ({24'h0, bus.ext_sram_wdata_i} << {lane, 3'b000}) : 32'h0;
        if (wr_ok) buf_tag <= word;
        state    <= wr_ok ? DIRTY : CLEAN;
      end else if (wr_ok) begin
        buf_data[{lane, 3'b000} +: 8] <= bus.ext_sram_wdata_i;
        buf_mask <= buf_mask | lane_bit;
        buf_tag  <= word;
        state    <= DIRTY;
      end else if (dirty && rd && flush_req_i) begin
        state <= FLUSH_PEND;
      end

      if (rd || wr || wb || !dirty) idle_cnt <= '0;
      else if (idle_cnt != '1)      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend      <= 1'b0;
      rd_oob       <= 1'b0;
      rd_hit       <= 1'b0;
      rd_lane      <= 2'b00;
      rd_byte      <= 8'h00;
      rdata_q      <= 8'h00;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rd_pend <= rd;
      rd_oob  <= ~in_win;
      rd_lane <= lane;
      rd_hit  <= in_win & buf_mask[lane] & (buf_tag == word);
      rd_byte <= buf_data[{lane, 3'b000} +: 8];
      if (rd_pend) begin
        if (rd_oob)      rdata_q <= 8'h00;
        else if (rd_hit) rdata_q <= rd_byte;
        else             rdata_q <= mem_rdata_i[{rd_lane, 3'b000} +: 8];
      end
      flush_done_q <= wb | (flush_req_i & ~dirty);
      err_q        <= err_q | ((rd | wr) & ~in_win) | (rd & wr);
    end
  end

  assign bus.ext_sram_rdata_o = rdata_q;
  assign flush_done_o         = flush_done_q;
  assign dirty_o              = dirty;
  assign err_o                = err_q;

endmodule

// File: tb/tb_ext_sram_target.sv
// Scoreboard bench for ext_sram_target: directed stimulus pushes expected macro
// accesses, read bytes and flush pulses; a negedge monitor pops and compares them.
module tb_ext_sram_target;

  typedef struct {
    int          cyc;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata = 32'h0;
  logic        flush_req;
  logic        flush_done_o;
  logic        dirty_o;
  logic        err_o;

  logic [31:0] mem [1024] = '{default: 32'h0};

  mem_exp_t exp_mem[$];
  rd_exp_t  exp_rd[$];
  int       exp_done[$];
  mem_exp_t mon_e;
  rd_exp_t  mon_r;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] t4_addr [6] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
  logic [9:0]  t4_word [6] = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd1};
  logic [7:0]  t4_data [6] = '{8'h5A, 8'h22, 8'h33, 8'h44, 8'h00, 8'hAB};

  ext_sram_target_if bus_if ();

  ext_sram_target dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus_if),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata),
    .flush_req_i  (flush_req),
    .flush_done_o (flush_done_o),
    .dirty_o      (dirty_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Macro model: word 1023 reads back a fixed pattern so the window edge is visible.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata <= (mem_addr_o == 10'h3FF) ? 32'hDEAD_BEEF : mem[mem_addr_o];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagMiss(input string name, input int want);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event due at cycle %0d, now cycle %0d", name, want, cyc);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (!mem_req_o) checkOutput("idle_bus_zero", {28'h0, mem_be_o} | mem_wdata_o, 32'h0);

      while (exp_mem.size() > 0 && exp_mem[0].cyc < cyc) begin
        flagMiss("missed_mem_access", exp_mem[0].cyc);
        void'(exp_mem.pop_front());
      end
      if (mem_req_o) begin
        if (exp_mem.size() == 0 || exp_mem[0].cyc != cyc) begin
          flagMiss("unexpected_mem_access", -1);
        end else begin
          mon_e = exp_mem.pop_front();
          checkOutput("mem_we", 32'(mem_we_o), 32'(mon_e.we));
          checkOutput("mem_be", 32'(mem_be_o), 32'(mon_e.be));
          checkOutput("mem_addr", 32'(mem_addr_o), 32'(mon_e.addr));
          checkOutput("mem_wdata", mem_wdata_o, mon_e.wdata);
        end
      end

      while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
        flagMiss("missed_rdata", exp_rd[0].cyc);
        void'(exp_rd.pop_front());
      end
      if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
        mon_r = exp_rd.pop_front();
        checkOutput("rdata", 32'(bus_if.ext_sram_rdata_o), 32'(mon_r.data));
      end

      while (exp_done.size() > 0 && exp_done[0] < cyc) begin
        flagMiss("missed_flush_done", exp_done[0]);
        void'(exp_done.pop_front());
      end
      if (flush_done_o) begin
        if (exp_done.size() == 0 || exp_done[0] != cyc) flagMiss("unexpected_flush_done", -1);
        else checkOutput("flush_done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [7:0] d, input logic fl);
    @(posedge clk_i);
    #1;
    bus_if.ext_sram_read_i  = rd;
    bus_if.ext_sram_write_i = wr;
    bus_if.ext_sram_addr_i  = a;
    bus_if.ext_sram_wdata_i = d;
    flush_req               = fl;
  endtask

  task automatic expectMem(input logic we, input logic [3:0] be, input logic [9:0] addr,
                           input logic [31:0] wd);
    exp_mem.push_back('{cyc, we, be, addr, wd});
  endtask

  task automatic expectRd(input logic [7:0] d);
    exp_rd.push_back('{cyc + 2, d});
  endtask

  task automatic expectDone();
    exp_done.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic doRead(input logic [31:0] a, input logic [9:0] w, input logic [7:0] d,
                        input logic fl);
    applyStimulus(1'b1, 1'b0, a, 8'h00, fl);
    expectMem(1'b0, 4'hF, w, 32'h0);
    expectRd(d);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rdata"}, 32'(bus_if.ext_sram_rdata_o), 32'h0);
    checkOutput({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    checkOutput({tag, "_mem_be"}, 32'(mem_be_o), 32'h0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr_o), 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    checkOutput({tag, "_flush_done"}, 32'(flush_done_o), 32'h0);
    checkOutput({tag, "_dirty"}, 32'(dirty_o), 32'h0);
    checkOutput({tag, "_err"}, 32'(err_o), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni                  = 1'b0;
    flush_req               = 1'b0;
    bus_if.ext_sram_read_i  = 1'b0;
    bus_if.ext_sram_write_i = 1'b0;
    bus_if.ext_sram_addr_i  = 32'h0;
    bus_if.ext_sram_wdata_i = 8'h00;
    #2;
    checkResetValues("reset");
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;

    // Fill word 0, let the idle timer write it back on the fourth idle cycle.
    doWrite(32'h0, 8'h11);
    doWrite(32'h1, 8'h22);
    doWrite(32'h2, 8'h33);
    doWrite(32'h3, 8'h44);
    idle(1);
    checkOutput("dirty_after_fill", 32'(dirty_o), 32'h1);
    idle(2);
    idle(1);
    expectMem(1'b1, 4'hF, 10'd0, 32'h4433_2211);
    expectDone();
    idle(1);
    checkOutput("dirty_after_timeout", 32'(dirty_o), 32'h0);

    // Read-after-write bypass from the buffer, then a lane the buffer lacks.
    doWrite(32'h5, 8'hAB);
    doRead(32'h5, 10'd1, 8'hAB, 1'b0);
    doRead(32'h4, 10'd1, 8'h00, 1'b0);
    idle(3);
    idle(1);
    expectMem(1'b1, 4'b0010, 10'd1, 32'h0000_AB00);
    expectDone();
    doRead(32'h5, 10'd1, 8'hAB, 1'b0);

    // Tag change evicts the old word in the same cycle.
    doWrite(32'h0, 8'h5A);
    doWrite(32'h8, 8'h7E);
    expectMem(1'b1, 4'b0001, 10'd0, 32'h0000_005A);
    expectDone();
    doRead(32'h8, 10'd2, 8'h7E, 1'b0);
    checkOutput("dirty_after_tag_change", 32'(dirty_o), 32'h1);
    doRead(32'h9, 10'd2, 8'h00, 1'b0);
    idle(3);
    idle(1);
    expectMem(1'b1, 4'b0001, 10'd2, 32'h0000_007E);
    expectDone();

    // Same-lane overwrite, forced flush, then a flush request with a clean buffer.
    doWrite(32'h10, 8'h10);
    doWrite(32'h10, 8'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    expectMem(1'b1, 4'b0001, 10'd4, 32'h0000_0020);
    expectDone();
    idle(1);
    checkOutput("dirty_after_forced_flush", 32'(dirty_o), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 1'b1);
    expectDone();
    idle(1);

    // Flush requested during a read burst waits for the first read-free cycle.
    doWrite(32'hC, 8'h99);
    for (int k = 0; k < 6; k++) doRead(t4_addr[k], t4_word[k], t4_data[k], k == 0);
    idle(1);
    expectMem(1'b1, 4'b0001, 10'd3, 32'h0000_0099);
    expectDone();
    idle(1);
    checkOutput("dirty_after_pending_flush", 32'(dirty_o), 32'h0);

    // Window edge: last byte is served by the macro, the next byte is rejected.
    checkOutput("err_before_oob", 32'(err_o), 32'h0);
    doRead(32'h0000_0FFF, 10'h3FF, 8'hDE, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 8'h00, 1'b0);
    expectRd(8'h00);
    idle(2);
    checkOutput("err_after_oob", 32'(err_o), 32'h1);

    // Asynchronous reset discards a dirty buffer without writing it back.
    doRead(32'h3, 10'd0, 8'h44, 1'b0);
    doWrite(32'h2, 8'hFF);
    idle(1);
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1 checkResetValues("midreset");
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    idle(6);
    checkOutput("dirty_after_midreset", 32'(dirty_o), 32'h0);
    checkOutput("err_after_midreset", 32'(err_o), 32'h0);

    // Simultaneous strobes: the read proceeds, the write is dropped.
    applyStimulus(1'b1, 1'b1, 32'h1, 8'h77, 1'b0);
    expectMem(1'b0, 4'hF, 10'd0, 32'h0);
    expectRd(8'h22);
    idle(1);
    checkOutput("err_after_rd_wr", 32'(err_o), 32'h1);
    checkOutput("dirty_after_rd_wr", 32'(dirty_o), 32'h0);
    idle(5);
    doRead(32'h1, 10'd0, 8'h22, 1'b0);
    idle(4);

    checkOutput("exp_mem_left", 32'(exp_mem.size()), 32'h0);
    checkOutput("exp_rd_left", 32'(exp_rd.size()), 32'h0);
    checkOutput("exp_done_left", 32'(exp_done.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_sram_target.md
EXT_SRAM_TARGET -- requirements
Module: ext_sram_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, window base on the byte bus.
REQ-002 SHALL have parameter WORDS_LOG2, default 10, macro depth 2^WORDS_LOG2 32-bit words (4 KiB).
REQ-003 SHALL have parameter IDLE_FLUSH, default 4, idle cycles before a dirty buffer is written back.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports clk_i and rst_ni.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 ext_sram_addr_i  in  32  byte address, qualified by a strobe.
REQ-008 ext_sram_read_i  in  1  byte read strobe, one cycle per access.
REQ-009 ext_sram_write_i  in  1  byte write strobe, one cycle per access.
REQ-010 ext_sram_wdata_i  in  8  write byte.
REQ-011 ext_sram_rdata_o  out  8  read byte, registered.
REQ-012 mem_req_o  out  1  macro access this cycle.
REQ-013 mem_we_o  out  1  macro write (1) / read (0).
REQ-014 mem_be_o  out  4  macro byte enables.
REQ-015 mem_addr_o  out  WORDS_LOG2  macro word address.
REQ-016 mem_wdata_o  out  32  macro write data.
REQ-017 mem_rdata_i  in  32  macro read data, valid the cycle after a read request.
REQ-018 flush_req_i  in  1  force write-back of the buffer.
REQ-019 flush_done_o  out  1  one-cycle pulse when a write-back completes.
REQ-020 dirty_o  out  1  buffer holds unwritten bytes.
REQ-021 err_o  out  1  sticky: out-of-window access or simultaneous read+write strobes.

Function
REQ-022 In-window: ext_sram_addr_i - BASE_ADDR < 4*2^WORDS_LOG2; word = offset[WORDS_LOG2+1:2], lane = offset[1:0]; subtraction modulo 2^32.
REQ-023 Write buffer: one 32-bit data register, one word tag, 4-bit valid mask; dirty_o = |mask.
REQ-024 Write, same tag or buffer clean: store byte at lane, set mask bit, load tag; no macro access; a repeated lane overwrites.
REQ-025 Write, different tag while dirty and no read this cycle: same-cycle macro write of old buffer (be = old mask), then buffer reloaded with only the new byte; flush_done_o pulses next cycle.
REQ-026 Read (cycle T): mem_req_o=1, mem_we_o=0, mem_addr_o=word at T; lane, buffer byte and its mask bit captured at T.
REQ-027 At T+1 selected byte = captured buffer byte if its mask bit was set, else mem_rdata_i lane byte; registered; ext_sram_rdata_o valid at T+2 (latency 2), held until the next read completes.
REQ-028 Macro port priority: read > flush; a pending flush (timeout, flush_req_i, tag change) waits for the first cycle with no read strobe.
REQ-029 Idle counter: increments each strobe-free cycle while dirty, clears on any strobe; at IDLE_FLUSH, write-back.
REQ-030 flush_req_i while clean: flush_done_o pulses next cycle with no macro access.
REQ-031 Write-back clears mask the same edge; state machine CLEAN -> DIRTY (first write) -> FLUSH_PEND (trigger blocked by read) -> CLEAN.
REQ-032 Out-of-window read: no macro access, ext_sram_rdata_o = 8'h00 at T+2, err_o set; out-of-window write dropped, err_o set.
REQ-033 Read and write strobes together: read executed, write dropped, err_o set.
REQ-034 mem_be_o = 4'b0000 and mem_wdata_o = 0 when mem_req_o = 0.

Reset
REQ-035 Asynchronous reset SHALL clear buffer, mask, tag, idle counter, pipeline and err_o without write-back; buffered data is discarded.
REQ-036 Reset values: ext_sram_rdata_o=8'h00, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, flush_done_o=0, dirty_o=0, err_o=0.

Verification
REQ-037 Writes 0x11,0x22,0x33,0x44 to 0x0..0x3, 4 idle cycles -> one macro write word 0, be 4'hF, data 32'h4433_2211, flush_done_o pulse.
REQ-038 Write 0xAB to 0x5, read 0x5 next cycle, macro word 1 = 32'h0 -> rdata 0xAB at T+2; read 0x4 -> 0x00 from macro.
REQ-039 Write 0x5A to 0x0, then write 0x7E to 0x8 -> macro write word 0 be 4'h1 same cycle; buffer tag 2, mask 4'h1.
REQ-040 Dirty buffer, back-to-back reads for 6 cycles then idle -> no write during reads; write-back on first idle cycle.
REQ-041 Read 0x0000_1000 with default params -> no mem_req_o, rdata 0x00, err_o=1; read+write together -> err_o=1, write absent.
REQ-042 Write 0xFF to 0x2, rst_ni low mid-sequence -> dirty_o=0, no macro write, all outputs at reset values.
